// File: rtl/rename_cp_table.sv
// rtl/rename_cp_table.sv - integer register rename table with a ring of branch checkpoints
// Renames a group per cycle with intra-group bypass and snapshots the map after every branch slot.
module rename_cp_table #(
    parameter int RENAME_WIDTH = 4,
    parameter int ARF_SIZE     = 32,
    parameter int PRF_SIZE     = 64,
    parameter int CP_DEPTH     = 4,
    localparam int AI = $clog2(ARF_SIZE),
    localparam int PI = $clog2(PRF_SIZE),
    localparam int CI = $clog2(CP_DEPTH)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [RENAME_WIDTH-1:0]          in_rd_valid,
    input  logic [RENAME_WIDTH-1:0][AI-1:0]  in_rs1,
    input  logic [RENAME_WIDTH-1:0][AI-1:0]  in_rs2,
    input  logic [RENAME_WIDTH-1:0][AI-1:0]  in_rd,
    input  logic [RENAME_WIDTH-1:0][PI-1:0]  in_new_prd,
    input  logic [RENAME_WIDTH-1:0]          in_br,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RENAME_WIDTH-1:0][PI-1:0]  out_prs1,
    output logic [RENAME_WIDTH-1:0][PI-1:0]  out_prs2,
    output logic [RENAME_WIDTH-1:0][PI-1:0]  out_prd,
    output logic [RENAME_WIDTH-1:0][PI-1:0]  out_prev_prd,
    output logic [RENAME_WIDTH-1:0]          out_prev_vld,
    output logic [RENAME_WIDTH-1:0][CI-1:0]  out_cp_idx,
    input  logic                             cp_release,
    input  logic                             recover,
    input  logic [CI-1:0]                    recover_idx,
    output logic [CI:0]                      cp_count
);
    localparam int BW = $clog2(RENAME_WIDTH + CP_DEPTH + 1) + 1;
    localparam logic [CI-1:0] ONE_H = 1;
    localparam logic [CI:0]   ONE_C = 1;

    logic [PI-1:0] r_map [ARF_SIZE];
    logic [PI-1:0] r_cp  [CP_DEPTH][ARF_SIZE];
    logic [CI-1:0] r_head;
    logic [CI:0]   r_count;
    logic          r_out_valid;
    logic [RENAME_WIDTH-1:0][PI-1:0] r_prs1, r_prs2, r_prd, r_prev_prd;
    logic [RENAME_WIDTH-1:0]         r_prev_vld;
    logic [RENAME_WIDTH-1:0][CI-1:0] r_cp_idx;

    logic [PI-1:0] w_run  [ARF_SIZE];
    logic [PI-1:0] w_snap [RENAME_WIDTH][ARF_SIZE];
    logic [RENAME_WIDTH-1:0][PI-1:0] w_prs1, w_prs2, w_prd, w_prev_prd;
    logic [RENAME_WIDTH-1:0]         w_ren;
    logic [RENAME_WIDTH-1:0][CI-1:0] w_cp_idx;
    logic [BW-1:0] w_nbr, w_free;
    logic [CI-1:0] w_dist;
    logic          w_accept, w_rel;

    // Walk the group in slot order so each slot sees the map as left by older slots.
    always_comb begin
        w_run      = r_map;
        w_nbr      = '0;
        w_prs1     = '0;
        w_prs2     = '0;
        w_prd      = '0;
        w_prev_prd = '0;
        w_ren      = '0;
        w_cp_idx   = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            w_ren[i]      = in_rd_valid[i] & (in_rd[i] != '0);
            w_prs1[i]     = (in_rs1[i] == '0) ? '0 : w_run[in_rs1[i]];
            w_prs2[i]     = (in_rs2[i] == '0) ? '0 : w_run[in_rs2[i]];
            w_prev_prd[i] = w_ren[i] ? w_run[in_rd[i]] : '0;
            w_prd[i]      = w_ren[i] ? in_new_prd[i] : '0;
            if (w_ren[i]) begin
                w_run[in_rd[i]] = in_new_prd[i];
            end
            w_snap[i]   = w_run;
            w_cp_idx[i] = r_head + r_count[CI-1:0] + w_nbr[CI-1:0];
            w_nbr       = w_nbr + BW'(in_br[i]);
        end
    end

    assign w_free   = BW'(CP_DEPTH) - BW'(r_count);
    assign in_ready = (~r_out_valid | out_ready) & ~recover & (w_free >= w_nbr);
    assign w_accept = in_valid & in_ready;
    assign w_rel    = cp_release & (r_count != '0);
    assign w_dist   = recover_idx - r_head;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < ARF_SIZE; r++) begin
                r_map[r] <= PI'(r);
            end
            r_head      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_prs1      <= '0;
            r_prs2      <= '0;
            r_prd       <= '0;
            r_prev_prd  <= '0;
            r_prev_vld  <= '0;
            r_cp_idx    <= '0;
        end else if (recover) begin
            // The restored checkpoint stays live; everything younger is dropped.
            r_map       <= r_cp[recover_idx];
            r_out_valid <= 1'b0;
            if (cp_release) begin
                r_head  <= r_head + ONE_H;
                r_count <= {1'b0, w_dist};
            end else begin
                r_count <= {1'b0, w_dist} + ONE_C;
            end
        end else begin
            if (w_accept) begin
                r_map <= w_run;
                for (int i = 0; i < RENAME_WIDTH; i++) begin
                    if (in_br[i]) begin
                        r_cp[w_cp_idx[i]] <= w_snap[i];
                    end
                end
                r_out_valid <= 1'b1;
                r_prs1      <= w_prs1;
                r_prs2      <= w_prs2;
                r_prd       <= w_prd;
                r_prev_prd  <= w_prev_prd;
                r_prev_vld  <= w_ren;
                r_cp_idx    <= w_cp_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_rel) begin
                r_head <= r_head + ONE_H;
            end
            r_count <= r_count + (w_accept ? w_nbr[CI:0] : '0) - {{CI{1'b0}}, w_rel};
        end
    end

    assign out_valid    = r_out_valid;
    assign out_prs1     = r_prs1;
    assign out_prs2     = r_prs2;
    assign out_prd      = r_prd;
    assign out_prev_prd = r_prev_prd;
    assign out_prev_vld = r_prev_vld;
    assign out_cp_idx   = r_cp_idx;
    assign cp_count     = r_count;
endmodule

// File: tb/tb_rename_cp_table.sv
// tb/tb_rename_cp_table.sv - self-checking bench for rename_cp_table
// Directed scenarios plus randomized traffic checked against an array-based reference model.
module tb_rename_cp_table;
    logic clock = 1'b0;
    logic reset;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_rd_valid, in_br, out_prev_vld;
    logic [3:0][4:0] in_rs1, in_rs2, in_rd;
    logic [3:0][5:0] in_new_prd, out_prs1, out_prs2, out_prd, out_prev_prd;
    logic [3:0][1:0] out_cp_idx;
    logic cp_release, recover;
    logic [1:0] recover_idx;
    logic [2:0] cp_count;

    int n_checks = 0;
    int n_pass = 0;

    int m_map [32];
    int m_cp  [4][32];
    int m_head, m_count;
    bit e_valid;
    int e_prs1 [4], e_prs2 [4], e_prd [4], e_prev [4], e_cpi [4];
    bit e_pv [4], e_br [4];

    always #5 clock = ~clock;

    rename_cp_table dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_valid(in_rd_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_new_prd(in_new_prd), .in_br(in_br), .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd), .out_prev_prd(out_prev_prd),
        .out_prev_vld(out_prev_vld), .out_cp_idx(out_cp_idx), .cp_release(cp_release),
        .recover(recover), .recover_idx(recover_idx), .cp_count(cp_count)
    );

    function automatic int m_nbr();
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(in_br[i]);
        return n;
    endfunction

    function automatic bit m_ready();
        return (!e_valid || out_ready) && !recover && (4 - m_count >= m_nbr());
    endfunction

    task automatic model_edge();
        int t [32];
        int k, d;
        bit ren;
        if (reset) begin
            for (int r = 0; r < 32; r++) m_map[r] = r;
            m_head = 0; m_count = 0; e_valid = 0;
            for (int i = 0; i < 4; i++) begin
                e_prs1[i] = 0; e_prs2[i] = 0; e_prd[i] = 0; e_prev[i] = 0; e_pv[i] = 0; e_br[i] = 0;
            end
        end else if (recover) begin
            m_map = m_cp[int'(recover_idx)];
            d = (int'(recover_idx) - m_head + 4) % 4;
            if (cp_release) begin
                m_head = (m_head + 1) % 4;
                m_count = d;
            end else begin
                m_count = d + 1;
            end
            e_valid = 0;
        end else begin
            k = 0;
            if (in_valid && m_ready()) begin
                t = m_map;
                for (int i = 0; i < 4; i++) begin
                    ren = in_rd_valid[i] && (in_rd[i] != 0);
                    e_prs1[i] = (in_rs1[i] == 0) ? 0 : t[in_rs1[i]];
                    e_prs2[i] = (in_rs2[i] == 0) ? 0 : t[in_rs2[i]];
                    e_prev[i] = ren ? t[in_rd[i]] : 0;
                    e_prd[i]  = ren ? int'(in_new_prd[i]) : 0;
                    e_pv[i]   = ren;
                    if (ren) t[in_rd[i]] = int'(in_new_prd[i]);
                    e_br[i] = in_br[i];
                    if (in_br[i]) begin
                        e_cpi[i] = (m_head + m_count + k) % 4;
                        m_cp[e_cpi[i]] = t;
                        k++;
                    end
                end
                m_map = t;
                e_valid = 1;
            end else if (out_ready) begin
                e_valid = 0;
            end
            if (cp_release && m_count > 0) begin
                m_head = (m_head + 1) % 4;
                m_count--;
            end
            m_count += k;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        assert (!(!reset && recover && cp_release && int'(recover_idx) == m_head));
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rd_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_new_prd = '0; in_br = '0; out_ready = 1; cp_release = 0; recover = 0; recover_idx = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0d want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0d want 1", in_ready); else n_pass++;
        n_checks++; if (cp_count !== 3'd0) $display("FAIL reset_cp_count got %0d want 0", cp_count); else n_pass++;
        n_checks++; if (out_prd !== '0 || out_prev_prd !== '0 || out_prs1 !== '0)
            $display("FAIL reset_out_data prd=%h prev=%h prs1=%h want 0", out_prd, out_prev_prd, out_prs1); else n_pass++;
    endtask

    task automatic test_spec_group();
        int want_prd [4] = '{40, 41, 0, 43};
        int want_prev [4] = '{1, 2, 0, 40};
        bit want_pv [4] = '{1, 1, 0, 1};
        do_reset();
        in_valid = 1; in_rd_valid = 4'b1111;
        in_rd[0] = 5'd1; in_rd[1] = 5'd2; in_rd[2] = 5'd0; in_rd[3] = 5'd1;
        for (int i = 0; i < 4; i++) in_new_prd[i] = 6'(40 + i);
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_prd[i] !== 6'(want_prd[i]) || out_prev_prd[i] !== 6'(want_prev[i]) || out_prev_vld[i] !== want_pv[i])
                $display("FAIL spec_group slot%0d got prd=%0d prev=%0d vld=%0d want %0d %0d %0d", i,
                         out_prd[i], out_prev_prd[i], out_prev_vld[i], want_prd[i], want_prev[i], want_pv[i]);
            else n_pass++;
        end
        idle_inputs();
        in_valid = 1; in_rs1[0] = 5'd1; in_rs2[0] = 5'd2;
        tick();
        n_checks++; if (out_prs1[0] !== 6'd43 || out_prs2[0] !== 6'd41)
            $display("FAIL spec_map_x1_x2 got %0d %0d want 43 41", out_prs1[0], out_prs2[0]); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_bypass();
        idle_inputs();
        in_valid = 1; in_rd_valid = 4'b0001; in_rd[0] = 5'd5; in_new_prd[0] = 6'd50;
        in_rs1[1] = 5'd5; in_rs2[1] = 5'd0;
        tick();
        n_checks++; if (out_prs1[1] !== 6'd50 || out_prs2[1] !== 6'd0)
            $display("FAIL bypass got prs1=%0d prs2=%0d want 50 0", out_prs1[1], out_prs2[1]); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_branch_recover();
        do_reset();
        in_valid = 1; in_rd_valid = 4'b1111; in_br = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            in_rd[i] = 5'($urandom_range(1, 31));
            in_new_prd[i] = 6'($urandom_range(32, 63));
        end
        tick();
        n_checks++; if (out_cp_idx[1] !== 2'd0 || out_cp_idx[3] !== 2'd1 || cp_count !== 3'd2)
            $display("FAIL branch_cp_idx got %0d %0d count=%0d want 0 1 2", out_cp_idx[1], out_cp_idx[3], cp_count); else n_pass++;
        in_br = 4'b0000; recover = 1; recover_idx = 2'd0;
        tick();
        n_checks++; if (cp_count !== 3'd1 || out_valid !== 1'b0)
            $display("FAIL recover_state got count=%0d valid=%0d want 1 0", cp_count, out_valid); else n_pass++;
        idle_inputs();
        for (int g = 0; g < 4; g++) begin
            in_valid = 1;
            for (int i = 0; i < 4; i++) begin
                in_rs1[i] = 5'(g * 8 + i);
                in_rs2[i] = 5'(g * 8 + 4 + i);
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (out_prs1[i] !== 6'(m_map[g * 8 + i]) || out_prs2[i] !== 6'(m_map[g * 8 + 4 + i]))
                    $display("FAIL recover_map grp%0d slot%0d got %0d %0d want %0d %0d", g, i,
                             out_prs1[i], out_prs2[i], m_map[g * 8 + i], m_map[g * 8 + 4 + i]);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        in_valid = 1; in_br = 4'b1111;
        tick();
        in_br = 4'b0001;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_ready_br got %0d want 0", in_ready); else n_pass++;
        in_br = 4'b0000;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL full_ready_nobr got %0d want 1", in_ready); else n_pass++;
        in_valid = 0; cp_release = 1;
        tick();
        cp_release = 0; in_valid = 1; in_br = 4'b0001;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL release_ready got %0d want 1", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_cp_idx[0] !== 2'd0 || cp_count !== 3'd4)
            $display("FAIL wrap_cp_idx got idx=%0d count=%0d want 0 4", out_cp_idx[0], cp_count); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [3:0][5:0] s_prd, s_prs1;
        do_reset();
        in_valid = 1; in_rd_valid = 4'b1111; out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_rd[i] = 5'(i + 3); in_rs1[i] = 5'(i + 2); in_new_prd[i] = 6'(33 + i);
        end
        tick();
        s_prd = out_prd; s_prs1 = out_prs1;
        for (int i = 0; i < 4; i++) in_new_prd[i] = 6'(50 + i);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready cyc%0d got %0d want 0", c, in_ready); else n_pass++;
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_prd !== s_prd || out_prs1 !== s_prs1)
                $display("FAIL stall_hold cyc%0d valid=%0d prd=%h want prd=%h", c, out_valid, out_prd, s_prd); else n_pass++;
        end
        out_ready = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL release_stall_ready got %0d want 1", in_ready); else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_prd[i] !== 6'(50 + i) || out_prev_prd[i] !== 6'(33 + i) || out_prs1[i] !== 6'(e_prs1[i]))
                $display("FAIL second_group slot%0d prd=%0d prev=%0d prs1=%0d want %0d %0d %0d", i,
                         out_prd[i], out_prev_prd[i], out_prs1[i], 50 + i, 33 + i, e_prs1[i]);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_recover_release();
        do_reset();
        in_valid = 1; in_br = 4'b0111;
        tick();
        idle_inputs();
        recover = 1; cp_release = 1; recover_idx = 2'd2;
        tick();
        n_checks++; if (cp_count !== 3'd2) $display("FAIL rec_rel_count got %0d want 2", cp_count); else n_pass++;
        idle_inputs();
        in_valid = 1; in_br = 4'b0001;
        tick();
        n_checks++; if (out_cp_idx[0] !== 2'd3 || cp_count !== 3'd3)
            $display("FAIL rec_rel_head got idx=%0d count=%0d want 3 3", out_cp_idx[0], cp_count); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        in_valid = 1; in_br = 4'b0011; out_ready = 0;
        tick();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        n_checks++; if (out_valid !== 1'b0 || cp_count !== 3'd0 || in_ready !== 1'b1)
            $display("FAIL mid_reset valid=%0d count=%0d ready=%0d want 0 0 1", out_valid, cp_count, in_ready); else n_pass++;
    endtask

    task automatic test_random();
        int off;
        do_reset();
        for (int it = 0; it < 600; it++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_rd_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                in_rs1[i] = 5'($urandom_range(0, 31) & ($urandom_range(0, 1) ? 31 : 7));
                in_rs2[i] = 5'($urandom_range(0, 31) & ($urandom_range(0, 1) ? 31 : 7));
                in_rd[i] = 5'($urandom_range(0, 31) & ($urandom_range(0, 1) ? 31 : 7));
                in_new_prd[i] = 6'($urandom_range(1, 63));
                in_br[i] = ($urandom_range(0, 5) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cp_release = (m_count > 0) && ($urandom_range(0, 3) == 0);
            recover = (m_count > 0) && ($urandom_range(0, 11) == 0);
            recover_idx = '0;
            if (recover) begin
                if (cp_release && m_count == 1) cp_release = 0;
                off = cp_release ? $urandom_range(1, m_count - 1) : $urandom_range(0, m_count - 1);
                recover_idx = 2'((m_head + off) % 4);
            end
            #1;
            n_checks++; if (in_ready !== m_ready()) $display("FAIL rand_in_ready it%0d got %0d want %0d", it, in_ready, m_ready()); else n_pass++;
            tick();
            n_checks++; if (out_valid !== e_valid || cp_count !== 3'(m_count))
                $display("FAIL rand_state it%0d valid=%0d count=%0d want %0d %0d", it, out_valid, cp_count, e_valid, m_count); else n_pass++;
            if (e_valid) begin
                for (int i = 0; i < 4; i++) begin
                    n_checks++;
                    if (out_prs1[i] !== 6'(e_prs1[i]) || out_prs2[i] !== 6'(e_prs2[i]) || out_prd[i] !== 6'(e_prd[i]) ||
                        out_prev_prd[i] !== 6'(e_prev[i]) || out_prev_vld[i] !== e_pv[i] ||
                        (e_br[i] && out_cp_idx[i] !== 2'(e_cpi[i])))
                        $display("FAIL rand_slot it%0d s%0d got %0d %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d %0d", it, i,
                                 out_prs1[i], out_prs2[i], out_prd[i], out_prev_prd[i], out_prev_vld[i], out_cp_idx[i],
                                 e_prs1[i], e_prs2[i], e_prd[i], e_prev[i], e_pv[i], e_cpi[i]);
                    else n_pass++;
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) e_cpi[i] = 0;
        reset = 1;
        test_reset();
        test_spec_group();
        test_bypass();
        test_branch_recover();
        test_full();
        test_back_to_back();
        test_recover_release();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
